sorted_frame_buffer: RTL and testbench

Ping-pong frame buffer between the sorting unit and the MLP. It captures the sorted ABS/ARG sample pairs that the sorting chains emit while `MLP_en` is high, and stores each frame into one of two banks. It then replays completed frames to the MLP over a valid/ready stream, which decouples MLP back-pressure from the free-running sorter.

---
 rtl/sorted_frame_buffer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_sorted_frame_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_frame_buffer.sv
// sorted_frame_buffer
// Two-bank ping-pong store between the sorting chains and the MLP. Frames
// captured while mlp_en is high land in alternating banks and are replayed in
// fill order over a valid/ready stream, so MLP back-pressure never stalls the
// sorter. Reads go through a registered RAM stage and an output register.
// The end-of-frame input is called final_i because `final` is a reserved word.
module sorted_frame_buffer #(
    parameter int N  = 1000,
    parameter int W  = 10,
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_abs,
    input  logic [W-1:0] in_arg,
    input  logic         mlp_en,
    input  logic         final_i,
    output logic [W-1:0] out_abs,
    output logic [W-1:0] out_arg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         overflow,
    input  logic         clr_ovf,
    output logic [15:0]  frames_done
);

    localparam int            LW        = AW + 1;
    localparam int            DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam bit            ONE_DEEP  = (N == 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bankState_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wrState_e;

    typedef enum logic {
        R_IDLE,
        R_DRAIN
    } rdState_e;

    // Sample storage; depth spans the full address space so every address is in range
    logic [2*W-1:0] mem0 [DEPTH];
    logic [2*W-1:0] mem1 [DEPTH];

    // Bank bookkeeping
    bankState_e    bankState_q [2];
    bankState_e    bankState_d [2];
    logic [LW-1:0] bankLen_q   [2];
    logic [LW-1:0] bankLen_d   [2];

    // Write side
    wrState_e      wrState_q, wrState_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic          wrTarget_q, wrTarget_d;
    logic          memWe;
    logic [AW-1:0] memWAddr;
    logic          wrStart;
    logic          wrComplete;
    logic [LW-1:0] wrLen;
    logic          dropSet;

    // Read side
    rdState_e      rdState_q, rdState_d;
    logic [LW-1:0] rdPtr_q, rdPtr_d;
    logic          rdTarget_q, rdTarget_d;
    logic [LW-1:0] rdLen;
    logic          rdStart;
    logic          rdRelease;
    logic          issue;
    logic [AW-1:0] issueAddr;
    logic          issueLast;

    // Replay pipeline: stage 1 is the RAM read register, stage 2 the output register
    logic           s1Valid_q, s1Valid_d;
    logic           s1Last_q;
    logic [2*W-1:0] rdData_q;
    logic           outValid_q;
    logic           outLast_q;
    logic [2*W-1:0] outData_q;
    logic           s2Load;
    logic           pipeSpace;
    logic           handshake;

    // Status
    logic          ovf_q, ovf_d;
    logic [15:0]   framesDone_q, framesDone_d;

    assign s2Load    = ~outValid_q | out_ready;
    assign pipeSpace = ~s1Valid_q | s2Load;
    assign handshake = outValid_q & out_ready;
    assign rdLen     = bankLen_q[rdTarget_q];
    assign issueLast = ({1'b0, issueAddr} == (rdLen - LW'(1)));
    assign s1Valid_d = issue | (s1Valid_q & ~s2Load);

    // Write FSM: start a frame in an empty bank, fill it, or discard pairs
    always_comb begin
        wrState_d  = wrState_q;
        wrPtr_d    = wrPtr_q;
        wrTarget_d = wrTarget_q;
        memWe      = 1'b0;
        memWAddr   = '0;
        wrStart    = 1'b0;
        wrComplete = 1'b0;
        wrLen      = '0;
        dropSet    = 1'b0;
        case (wrState_q)
            W_IDLE: begin
                if (mlp_en) begin
                    if (bankState_q[wrTarget_q] == BANK_EMPTY) begin
                        memWe   = 1'b1;
                        wrStart = 1'b1;
                        if (final_i || ONE_DEEP) begin
                            wrComplete = 1'b1;
                            wrLen      = LW'(1);
                            wrTarget_d = ~wrTarget_q;
                            wrPtr_d    = '0;
                            wrState_d  = final_i ? W_IDLE : W_DROP;
                        end else begin
                            wrPtr_d   = AW'(1);
                            wrState_d = W_FILL;
                        end
                    end else begin
                        dropSet   = 1'b1;
                        wrState_d = final_i ? W_IDLE : W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (mlp_en) begin
                    memWe    = 1'b1;
                    memWAddr = wrPtr_q;
                    wrPtr_d  = wrPtr_q + AW'(1);
                    if (final_i || (wrPtr_q == LAST_ADDR)) begin
                        wrComplete = 1'b1;
                        wrLen      = {1'b0, wrPtr_q} + LW'(1);
                        wrTarget_d = ~wrTarget_q;
                        wrPtr_d    = '0;
                        // A truncated frame still owns its tail: swallow it until final
                        wrState_d  = final_i ? W_IDLE : W_DROP;
                    end
                end
            end
            W_DROP: begin
                if (mlp_en && final_i) begin
                    wrState_d = W_IDLE;
                end
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    // Read FSM: claim the next full bank, issue reads while the pipe has room, release on last handshake
    always_comb begin
        rdState_d    = rdState_q;
        rdPtr_d      = rdPtr_q;
        rdTarget_d   = rdTarget_q;
        rdStart      = 1'b0;
        rdRelease    = 1'b0;
        issue        = 1'b0;
        issueAddr    = '0;
        framesDone_d = framesDone_q;
        case (rdState_q)
            R_IDLE: begin
                if ((bankState_q[rdTarget_q] == BANK_FULL) && pipeSpace) begin
                    rdStart   = 1'b1;
                    issue     = 1'b1;
                    rdPtr_d   = LW'(1);
                    rdState_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if ((rdPtr_q != rdLen) && pipeSpace) begin
                    issue     = 1'b1;
                    issueAddr = rdPtr_q[AW-1:0];
                    rdPtr_d   = rdPtr_q + LW'(1);
                end
                if (handshake && outLast_q) begin
                    rdRelease    = 1'b1;
                    rdTarget_d   = ~rdTarget_q;
                    framesDone_d = framesDone_q + 16'd1;
                    rdPtr_d      = '0;
                    rdState_d    = R_IDLE;
                end
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    // Merge write-side and read-side bank transitions; the two sides never act on the same bank
    always_comb begin
        bankState_d = bankState_q;
        bankLen_d   = bankLen_q;
        if (wrStart) begin
            bankState_d[wrTarget_q] = BANK_FILLING;
        end
        if (wrComplete) begin
            bankState_d[wrTarget_q] = BANK_FULL;
            bankLen_d[wrTarget_q]   = wrLen;
        end
        if (rdStart) begin
            bankState_d[rdTarget_q] = BANK_DRAINING;
        end
        if (rdRelease) begin
            bankState_d[rdTarget_q] = BANK_EMPTY;
        end
    end

    // Sticky overflow: a new drop beats a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (dropSet) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Sample RAM write port and registered read port (no reset on storage)
    always_ff @(posedge clk) begin
        if (memWe) begin
            if (wrTarget_q) begin
                mem1[memWAddr] <= {in_abs, in_arg};
            end else begin
                mem0[memWAddr] <= {in_abs, in_arg};
            end
        end
        if (issue) begin
            rdData_q <= rdTarget_q ? mem1[issueAddr] : mem0[issueAddr];
        end
    end

    // Control state, bank bookkeeping, pipeline flags and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bankState_q[0] <= BANK_EMPTY;
            bankState_q[1] <= BANK_EMPTY;
            bankLen_q[0]   <= '0;
            bankLen_q[1]   <= '0;
            wrState_q      <= W_IDLE;
            wrPtr_q        <= '0;
            wrTarget_q     <= 1'b0;
            rdState_q      <= R_IDLE;
            rdPtr_q        <= '0;
            rdTarget_q     <= 1'b0;
            s1Valid_q      <= 1'b0;
            s1Last_q       <= 1'b0;
            outValid_q     <= 1'b0;
            outLast_q      <= 1'b0;
            outData_q      <= '0;
            ovf_q          <= 1'b0;
            framesDone_q   <= '0;
        end else begin
            bankState_q  <= bankState_d;
            bankLen_q    <= bankLen_d;
            wrState_q    <= wrState_d;
            wrPtr_q      <= wrPtr_d;
            wrTarget_q   <= wrTarget_d;
            rdState_q    <= rdState_d;
            rdPtr_q      <= rdPtr_d;
            rdTarget_q   <= rdTarget_d;
            s1Valid_q    <= s1Valid_d;
            ovf_q        <= ovf_d;
            framesDone_q <= framesDone_d;
            if (issue) begin
                s1Last_q <= issueLast;
            end
            if (s2Load) begin
                outValid_q <= s1Valid_q;
                outLast_q  <= s1Valid_q & s1Last_q;
                if (s1Valid_q) begin
                    outData_q <= rdData_q;
                end
            end
        end
    end

    assign out_abs     = outData_q[2*W-1:W];
    assign out_arg     = outData_q[W-1:0];
    assign out_valid   = outValid_q;
    assign out_last    = outLast_q;
    assign overflow    = ovf_q;
    assign frames_done = framesDone_q;

endmodule

// File: tb/tb_sorted_frame_buffer.sv
// tb_sorted_frame_buffer
// Drives whole frames into the buffer and checks the replayed stream against a
// frame-level model: a frame is kept when fewer than two kept frames are still
// undelivered, keeps at most N pairs, and comes out in order with last marked.
module tb_sorted_frame_buffer;

    localparam int N  = 8;
    localparam int W  = 10;
    localparam int AW = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_abs;
    logic [W-1:0] in_arg;
    logic         mlp_en;
    logic         finalIn;
    logic [W-1:0] out_abs;
    logic [W-1:0] out_arg;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         overflow;
    logic         clr_ovf;
    logic [15:0]  frames_done;

    int           assertCount;
    int           failCount;
    logic [2*W:0] expQ [$];
    int           acceptedCount;
    int           releasedCount;
    int           relBase;
    int           framesExp;
    logic         ovfExp;
    int           hsCount;
    int           cycleNum;
    int           readyMode;
    logic         holdValid;
    logic [2*W:0] heldOut;
    logic         sampledValid;

    sorted_frame_buffer #(.N(N), .W(W), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_abs      (in_abs),
        .in_arg      (in_arg),
        .mlp_en      (mlp_en),
        .final_i     (finalIn),
        .out_abs     (out_abs),
        .out_arg     (out_arg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf),
        .frames_done (frames_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Output monitor, run on the falling edge ahead of the edge that completes a handshake
    task automatic sampleOutputs();
        logic [2*W:0] obs;
        logic [2*W:0] expPair;
        obs          = {out_last, out_abs, out_arg};
        sampledValid = out_valid;
        if (holdValid) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_hold", 32'(obs), 32'(heldOut));
        end
        if (out_valid && out_ready) begin
            hsCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pair", 32'(out_valid), 32'd0);
            end else begin
                expPair = expQ.pop_front();
                checkOutput("pair", 32'(obs), 32'(expPair));
            end
            if (out_last) releasedCount++;
        end
        holdValid = out_valid && !out_ready;
        heldOut   = obs;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        #1;
        cycleNum++;
        case (readyMode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ((cycleNum % 4) == 0) || ((cycleNum % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic setReady(input int mode);
        readyMode = mode;
        if (mode == 0) out_ready = 1'b0;
        if (mode == 1) out_ready = 1'b1;
    endtask

    task automatic idle(input int cycles);
        mlp_en  = 1'b0;
        finalIn = 1'b0;
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    // Send one frame of len pairs, final on the last, and predict what comes out
    task automatic applyStimulus(input int len, input bit randomData, input bit clrFirst);
        int           stored;
        bit           keep;
        logic [W-1:0] a;
        logic [W-1:0] b;
        stored = (len < N) ? len : N;
        keep   = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (randomData) begin
                a = W'($urandom_range(0, 2 ** W - 1));
                b = W'($urandom_range(0, 2 ** W - 1));
            end else begin
                a = W'(k);
                b = W'(100 + k);
            end
            if (k == 0) begin
                if (clrFirst) ovfExp = 1'b0;
                if ((acceptedCount - (releasedCount - relBase)) < 2) begin
                    keep = 1'b1;
                    acceptedCount++;
                    framesExp++;
                end else begin
                    ovfExp = 1'b1;
                end
            end
            if (keep && (k < N)) expQ.push_back({(k == stored - 1), a, b});
            mlp_en  = 1'b1;
            in_abs  = a;
            in_arg  = b;
            finalIn = (k == len - 1);
            clr_ovf = clrFirst && (k == 0);
            stepCycle();
        end
        mlp_en  = 1'b0;
        finalIn = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (((expQ.size() != 0) || out_valid) && (n < budget)) begin
            stepCycle();
            n++;
        end
        checkOutput("drain_left", 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_abs", 32'(out_abs), 32'd0);
        checkOutput("rst_arg", 32'(out_arg), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_frames", 32'(frames_done), 32'd0);
    endtask

    // Directed sequence followed by randomized frames
    initial begin
        int firstValid;
        int hsBase;
        assertCount   = 0;
        failCount     = 0;
        acceptedCount = 0;
        releasedCount = 0;
        relBase       = 0;
        framesExp     = 0;
        ovfExp        = 1'b0;
        hsCount       = 0;
        cycleNum      = 0;
        holdValid     = 1'b0;
        heldOut       = '0;
        sampledValid  = 1'b0;
        reset         = 1'b0;
        mlp_en        = 1'b0;
        finalIn       = 1'b0;
        in_abs        = '0;
        in_arg        = '0;
        clr_ovf       = 1'b0;
        setReady(0);

        stepCycle();
        stepCycle();
        checkResetOutputs();
        reset = 1'b1;
        setReady(1);
        stepCycle();

        $display("[TB] full frame, latency and throughput");
        applyStimulus(8, 1'b0, 1'b0);
        firstValid = 0;
        hsBase     = hsCount;
        for (int n = 1; n <= 10; n++) begin
            stepCycle();
            if (sampledValid && (firstValid == 0)) firstValid = n;
        end
        checkOutput("read_latency", 32'(firstValid), 32'd3);
        checkOutput("full_handshakes", 32'(hsCount - hsBase), 32'd8);
        checkOutput("full_frames_done", 32'(frames_done), 32'(16'(framesExp)));
        waitDrain(50);

        $display("[TB] short frame");
        hsBase = hsCount;
        applyStimulus(3, 1'b0, 1'b0);
        waitDrain(50);
        checkOutput("short_handshakes", 32'(hsCount - hsBase), 32'd3);

        $display("[TB] truncated frame");
        hsBase = hsCount;
        applyStimulus(11, 1'b0, 1'b0);
        waitDrain(50);
        checkOutput("trunc_handshakes", 32'(hsCount - hsBase), 32'd8);
        checkOutput("trunc_ovf", 32'(overflow), 32'd0);

        $display("[TB] final without mlp_en");
        mlp_en  = 1'b0;
        finalIn = 1'b1;
        in_abs  = W'($urandom_range(0, 2 ** W - 1));
        stepCycle();
        stepCycle();
        idle(6);
        checkOutput("stray_final_valid", 32'(out_valid), 32'd0);

        $display("[TB] back-pressure");
        setReady(2);
        hsBase = hsCount;
        applyStimulus(8, 1'b0, 1'b0);
        waitDrain(100);
        checkOutput("bp_handshakes", 32'(hsCount - hsBase), 32'd8);
        setReady(1);
        idle(2);

        $display("[TB] overflow");
        setReady(0);
        hsBase = hsCount;
        applyStimulus(8, 1'b0, 1'b0);
        applyStimulus(8, 1'b0, 1'b0);
        applyStimulus(8, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(overflow), 32'(ovfExp));
        applyStimulus(2, 1'b1, 1'b1);
        checkOutput("ovf_set_wins", 32'(overflow), 32'(ovfExp));
        setReady(1);
        waitDrain(100);
        checkOutput("ovf_handshakes", 32'(hsCount - hsBase), 32'd16);
        checkOutput("ovf_frames_done", 32'(frames_done), 32'(16'(framesExp)));
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        stepCycle();
        clr_ovf = 1'b0;
        ovfExp  = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 32'(ovfExp));

        $display("[TB] ping-pong");
        for (int f = 0; f < 6; f++) begin
            applyStimulus(8, 1'b1, 1'b0);
            idle(4);
        end
        waitDrain(100);
        checkOutput("pp_ovf", 32'(overflow), 32'd0);
        checkOutput("pp_frames_done", 32'(frames_done), 32'(16'(framesExp)));

        $display("[TB] random frames");
        setReady(3);
        for (int f = 0; f < 30; f++) begin
            applyStimulus($urandom_range(1, 11), 1'b1, 1'b0);
            idle($urandom_range(0, 3));
        end
        setReady(1);
        waitDrain(400);
        checkOutput("rand_frames_done", 32'(frames_done), 32'(16'(framesExp)));
        checkOutput("rand_ovf", 32'(overflow), 32'(ovfExp));
        clr_ovf = 1'b1;
        stepCycle();
        clr_ovf = 1'b0;
        ovfExp  = 1'b0;

        $display("[TB] reset mid-drain");
        applyStimulus(8, 1'b1, 1'b0);
        hsBase = hsCount;
        for (int n = 0; (n < 40) && ((hsCount - hsBase) < 4); n++) stepCycle();
        checkOutput("pre_reset_handshakes", 32'(hsCount - hsBase), 32'd4);
        reset = 1'b0;
        #1;
        checkResetOutputs();
        expQ.delete();
        acceptedCount = 0;
        relBase       = releasedCount;
        framesExp     = 0;
        ovfExp        = 1'b0;
        holdValid     = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b1;
        idle(12);
        checkOutput("post_reset_quiet", 32'(out_valid), 32'd0);
        hsBase = hsCount;
        applyStimulus(8, 1'b0, 1'b0);
        waitDrain(50);
        checkOutput("post_reset_handshakes", 32'(hsCount - hsBase), 32'd8);
        checkOutput("post_reset_frames_done", 32'(frames_done), 32'(16'(framesExp)));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
